// File: rtl/baud_gen_pkg.sv
// ---------------------------------------------------------------------------
// baud_gen_pkg
//   Shared constants and helpers for the fractional baud generator.
//   MIN_INT_DIVISOR : smallest integer divisor honoured; smaller values are
//                     raised to it so no tick period is shorter than 2 clocks.
//   OVERSAMPLE      : oversample ticks per bit for the default configuration.
//   MID_COUNT       : oversample count at which the mid-bit strobe fires.
//   oversampleOf()  : oversample ratio for a given log2 setting.
//   midCountOf()    : mid-bit count for a given log2 setting.
// ---------------------------------------------------------------------------
package baud_gen_pkg;

  localparam int MIN_INT_DIVISOR         = 2;
  localparam int DEFAULT_OVERSAMPLE_LOG2 = 4;
  localparam int OVERSAMPLE              = 1 << DEFAULT_OVERSAMPLE_LOG2;
  localparam int MID_COUNT               = OVERSAMPLE / 2;

  function automatic int oversampleOf(input int log2Ratio);
    return 1 << log2Ratio;
  endfunction

  function automatic int midCountOf(input int log2Ratio);
    return (1 << log2Ratio) / 2;
  endfunction

endpackage

// File: rtl/oversample_counter.sv
// ---------------------------------------------------------------------------
// oversample_counter
//   Counts oversample ticks within one bit and decodes the bit and mid-bit
//   strobes. Both strobes are registered so they line up with the registered
//   oversample tick in the parent.
//   Ports:
//     clock      in  system clock
//     reset      in  asynchronous active-low reset
//     tick       in  an oversample period ends on this clock edge
//     restart    in  reload the count to OVERSAMPLE-1 (priority over tick)
//     bitTick    out 1-clock strobe on the tick where the count was 0
//     midBitTick out 1-clock strobe on the tick where the count was OVERSAMPLE/2
//   Strobes are single-cycle with no backpressure: a consumer samples them
//   on the clock edge where they are high or misses them.
// ---------------------------------------------------------------------------
module oversample_counter
  import baud_gen_pkg::*;
#(
  parameter int OVERSAMPLE_LOG2 = DEFAULT_OVERSAMPLE_LOG2
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic restart,
  output logic bitTick,
  output logic midBitTick
);

  localparam int Oversample = oversampleOf(OVERSAMPLE_LOG2);
  localparam logic [OVERSAMPLE_LOG2-1:0] TopCount = OVERSAMPLE_LOG2'(Oversample - 1);
  localparam logic [OVERSAMPLE_LOG2-1:0] MidCount = OVERSAMPLE_LOG2'(midCountOf(OVERSAMPLE_LOG2));
  localparam logic [OVERSAMPLE_LOG2-1:0] OneCount = OVERSAMPLE_LOG2'(1);

  logic [OVERSAMPLE_LOG2-1:0] ovCount;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovCount    <= TopCount;
      bitTick    <= 1'b0;
      midBitTick <= 1'b0;
    end else if (restart) begin
      ovCount    <= TopCount;
      bitTick    <= 1'b0;
      midBitTick <= 1'b0;
    end else begin
      bitTick    <= tick && (ovCount == '0);
      midBitTick <= tick && (ovCount == MidCount);
      // The ratio is a power of two, so 0 - 1 wraps straight to TopCount.
      if (tick) begin
        ovCount <= ovCount - OneCount;
      end
    end
  end

endmodule

// File: rtl/fractional_baud_generator.sv
// ---------------------------------------------------------------------------
// fractional_baud_generator
//   Divides the system clock by divisorInt + divisorFrac/2^FRAC_WIDTH to make
//   an oversample tick, plus bit and mid-bit strobes every OVERSAMPLE ticks.
//   Ports:
//     clock          in  system clock
//     reset          in  asynchronous active-low reset
//     enable         in  1 = run, 0 = hold in the reload state (no ticks)
//     resync         in  1-cycle pulse restarting the bit phase
//     divisorInt     in  integer part of the divisor (0 and 1 act as 2)
//     divisorFrac    in  fractional part of the divisor
//     oversampleTick out 1-clock strobe per oversample period
//     bitTick        out 1-clock strobe every OVERSAMPLE-th oversample tick
//     midBitTick     out 1-clock strobe on the mid-bit oversample tick
//   All strobes are registered and single-cycle with no backpressure.
// ---------------------------------------------------------------------------
module fractional_baud_generator
  import baud_gen_pkg::*;
#(
  parameter int INT_WIDTH       = 16,
  parameter int FRAC_WIDTH      = 8,
  parameter int OVERSAMPLE_LOG2 = DEFAULT_OVERSAMPLE_LOG2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  resync,
  input  logic [INT_WIDTH-1:0]  divisorInt,
  input  logic [FRAC_WIDTH-1:0] divisorFrac,
  output logic                  oversampleTick,
  output logic                  bitTick,
  output logic                  midBitTick
);

  localparam logic [INT_WIDTH-1:0] MinInt = INT_WIDTH'(MIN_INT_DIVISOR);
  localparam logic [INT_WIDTH-1:0] OneInt = INT_WIDTH'(1);

  // primed is 0 only on the first clock after reset. Until then the
  // divisor-dependent state (count and fractional shadow) is taken straight
  // from the inputs, which gives a data-dependent reset value without an
  // asynchronous data load.
  logic                  primed;
  logic [FRAC_WIDTH-1:0] shadowFrac;
  logic [FRAC_WIDTH-1:0] fracAcc;
  logic [INT_WIDTH-1:0]  cycleCnt;

  logic [INT_WIDTH-1:0]  effIntIn;
  logic [INT_WIDTH-1:0]  activeCnt;
  logic [FRAC_WIDTH-1:0] activeFrac;
  logic [FRAC_WIDTH:0]   fracSum;
  logic [INT_WIDTH-1:0]  nextPeriodCnt;
  logic                  restart;
  logic                  periodEnd;
  logic                  loadShadow;

  assign effIntIn   = (divisorInt < MinInt) ? MinInt : divisorInt;
  assign activeFrac = primed ? shadowFrac : divisorFrac;
  assign activeCnt  = primed ? cycleCnt : (effIntIn - OneInt);

  // resync reloads exactly like a disabled cycle and wins over a period end.
  assign restart   = resync || !enable;
  assign periodEnd = !restart && (activeCnt == '0);

  // The fraction of the period that just ended is accumulated; its carry
  // stretches the next period by one clock. The integer part is taken from
  // the inputs at this edge and lives on only inside cycleCnt, so a divisor
  // change never alters a period already under way.
  assign fracSum       = {1'b0, fracAcc} + {1'b0, activeFrac};
  assign nextPeriodCnt = effIntIn - OneInt + INT_WIDTH'(fracSum[FRAC_WIDTH]);
  assign loadShadow    = !primed || restart || periodEnd;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      primed         <= 1'b0;
      shadowFrac     <= '0;
      fracAcc        <= '0;
      cycleCnt       <= '0;
      oversampleTick <= 1'b0;
    end else begin
      primed <= 1'b1;
      if (loadShadow) begin
        shadowFrac <= divisorFrac;
      end
      if (restart) begin
        cycleCnt       <= effIntIn - OneInt;
        fracAcc        <= '0;
        oversampleTick <= 1'b0;
      end else if (periodEnd) begin
        cycleCnt       <= nextPeriodCnt;
        fracAcc        <= fracSum[FRAC_WIDTH-1:0];
        oversampleTick <= 1'b1;
      end else begin
        cycleCnt       <= activeCnt - OneInt;
        oversampleTick <= 1'b0;
      end
    end
  end

  oversample_counter #(
    .OVERSAMPLE_LOG2(OVERSAMPLE_LOG2)
  ) u_oversample_counter (
    .clock     (clock),
    .reset     (reset),
    .tick      (periodEnd),
    .restart   (restart),
    .bitTick   (bitTick),
    .midBitTick(midBitTick)
  );

endmodule
